// File: rtl/seq_alu.sv
// seq_alu: registered N-bit ALU with an iterative shift-add multiply; MUL is compiled in only with SEQ_ALU_MUL_EN.
// Latency: single-cycle ops give out_valid right after the accept edge; MUL gives it N edges after the accept edge.
// Backpressure: one op in flight; in_ready stays low until the result transfers, and C/flags hold while out_ready is low.
module seq_alu #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   select,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] C,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow,
    output logic         err
);

    localparam int SW = $clog2(N);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [SW-1:0] CNT_INIT = SW'(N - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic         is_sub;
    logic [N-1:0] opb;
    logic [N:0]   sum_ext;
    logic         slt;
    logic [N-1:0] alu_res;
    logic         alu_cy;
    logic         alu_ov;
    logic         alu_err;
`ifdef SEQ_ALU_MUL_EN
    logic          is_mul;
    logic [N-1:0]  mcand;
    logic [N-1:0]  mplier;
    logic [N-1:0]  acc;
    logic [N-1:0]  acc_nxt;
    logic [SW-1:0] cnt;
`endif

    // Single-cycle datapath works straight off the inputs; its result is captured on the accept edge.
    always_comb begin
        is_sub  = (select == OP_SUB);
        opb     = is_sub ? ~B : B;
        sum_ext = {1'b0, A} + {1'b0, opb} + {{N{1'b0}}, is_sub};
        slt     = $signed(A) < $signed(B);
        alu_res = '0;
        alu_cy  = 1'b0;
        alu_ov  = 1'b0;
        alu_err = 1'b0;
`ifdef SEQ_ALU_MUL_EN
        is_mul  = 1'b0;
`endif
        case (select)
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_ADD, OP_SUB: begin
                alu_res = sum_ext[N-1:0];
                alu_cy  = sum_ext[N];
                alu_ov  = (A[N-1] == opb[N-1]) && (sum_ext[N-1] != A[N-1]);
            end
            OP_SLT: alu_res = {{(N-1){1'b0}}, slt};
            OP_SLL: alu_res = A << B[SW-1:0];
            OP_SRL: alu_res = A >> B[SW-1:0];
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: is_mul = 1'b1;
`endif
            default: alu_err = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            C         <= '0;
            zero      <= 1'b1;
            negative  <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
                        if (is_mul) begin
                            mcand  <= A;
                            mplier <= B;
                            acc    <= '0;
                            cnt    <= CNT_INIT;
                            state  <= BUSY;
                        end else
`endif
                        begin
                            C         <= alu_res;
                            zero      <= ~|alu_res;
                            negative  <= alu_res[N-1];
                            carry     <= alu_cy;
                            overflow  <= alu_ov;
                            err       <= alu_err;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                // Multiplier consumed LSB first; multiplicand shifts left, truncated to N bits.
                BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - SW'(1);
                    if (cnt == '0) begin
                        C         <= acc_nxt;
                        zero      <= ~|acc_nxt;
                        negative  <= acc_nxt[N-1];
                        carry     <= 1'b0;
                        overflow  <= 1'b0;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at N=8: expected results queued at acceptance, popped when out_valid rises.
module tb_seq_alu;

    localparam int N = 8;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] c;
        logic       z;
        logic       n;
        logic       cy;
        logic       ov;
        logic       er;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic [3:0] sel = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] c_out;
    logic       zero, negative, carry, overflow, err;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // {select, A, B}
    logic [19:0] ops [16] = '{
        {4'h2, 8'h7F, 8'h01}, {4'h6, 8'h05, 8'h05}, {4'h7, 8'hFF, 8'h01}, {4'h8, 8'h0D, 8'h0B},
        {4'h8, 8'h10, 8'h10}, {4'h4, 8'h01, 8'h07}, {4'h5, 8'h80, 8'h07}, {4'hF, 8'h12, 8'h34},
        {4'h8, 8'hFF, 8'hFF}, {4'h0, 8'hF0, 8'h3C}, {4'h1, 8'hF0, 8'h0F}, {4'h3, 8'hAA, 8'hFF},
        {4'h6, 8'h00, 8'h01}, {4'h6, 8'h80, 8'h01}, {4'h4, 8'hA5, 8'hF8}, {4'h5, 8'h81, 8'hF9}
    };

    always #5 clk = ~clk;

    seq_alu #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a_in),
        .B         (b_in),
        .select    (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (c_out),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .err       (err)
    );

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        res_t        r;
        logic [15:0] w;
        int          sa;
        int          sb;
        r  = '0;
        w  = '0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (s)
            4'h0: r.c = a & b;
            4'h1: r.c = a | b;
            4'h3: r.c = a ^ b;
            4'h2: begin
                w    = {8'h00, a} + {8'h00, b};
                r.c  = w[7:0];
                r.cy = w[8];
                r.ov = (sa + sb > 127) || (sa + sb < -128);
            end
            4'h6: begin
                w    = {8'h00, a} + {8'h00, ~b} + 16'd1;
                r.c  = w[7:0];
                r.cy = w[8];
                r.ov = (sa - sb > 127) || (sa - sb < -128);
            end
            4'h7: r.c = (sa < sb) ? 8'd1 : 8'd0;
            4'h4: r.c = a << b[2:0];
            4'h5: r.c = a >> b[2:0];
            4'h8: begin
                if (MUL_EN) begin
                    w   = {8'h00, a} * {8'h00, b};
                    r.c = w[7:0];
                end else begin
                    r.er = 1'b1;
                end
            end
            default: r.er = 1'b1;
        endcase
        r.z = (r.c == 8'h00);
        r.n = r.c[7];
        return r;
    endfunction

    function automatic int exp_lat(input logic [3:0] s);
        return (s == 4'h8 && MUL_EN) ? N : 0;
    endfunction

    function automatic res_t dut_res();
        return {c_out, zero, negative, carry, overflow, err};
    endfunction

    // Presents an op and returns how many edges passed without acceptance.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s, output int waited);
        bit was_rdy;
        a_in = a; b_in = b; sel = s; in_valid = 1'b1;
        waited = 0;
        for (int i = 0; i < 50; i++) begin
            was_rdy = in_ready;
            @(posedge clk); #1;
            if (was_rdy) break;
            waited++;
        end
        in_valid = 1'b0;
        if (waited < 50) exp_q.push_back(model(a, b, s));
        a_in = 8'($urandom); b_in = 8'($urandom); sel = 4'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic transfer();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int   w;
        int   seen;
        logic [3:0] s;
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({out_valid, c_out, zero, negative, carry, overflow, err} !== {1'b0, 8'h00, 1'b1, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_values: got ov=%b C=%h z=%b n=%b c=%b v=%b e=%b, want ov=0 C=00 z=1 rest 0",
                     out_valid, c_out, zero, negative, carry, overflow, err);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
        s = MUL_EN ? 4'h8 : 4'h2;
        issue(8'h0D, 8'h0B, s, w);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || c_out !== 8'h00 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_abort: out_valid=%b C=%h zero=%b, want 0/00/1", out_valid, c_out, zero);
        end
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_stale: out_valid cycles=%0d in_ready=%b, want 0 and 1", seen, in_ready);
        end
    endtask

    task automatic test_ops();
        int   w;
        int   lat;
        res_t e;
        for (int i = 0; i < 16; i++) begin
            issue(ops[i][15:8], ops[i][7:0], ops[i][19:16], w);
            wait_out(lat);
            n_checks++;
            if (w != 0 || lat != exp_lat(ops[i][19:16])) begin
                n_fail++;
                $display("FAIL op%0d_latency: accept_wait=%0d lat=%0d, want 0 and %0d", i, w, lat, exp_lat(ops[i][19:16]));
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (dut_res() !== e) begin
                    n_fail++;
                    $display("FAIL op%0d_result sel=%h A=%h B=%h: got {C,z,n,c,v,e}=%h/%b%b%b%b%b want %h/%b%b%b%b%b",
                             i, ops[i][19:16], ops[i][15:8], ops[i][7:0], c_out, zero, negative, carry, overflow, err,
                             e.c, e.z, e.n, e.cy, e.ov, e.er);
                end
            end
            transfer();
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL op%0d_handshake: in_ready=%b out_valid=%b, want 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int   w;
        int   lat;
        res_t e;
        res_t e2;
        issue(8'h7F, 8'h01, 4'h2, w);
        wait_out(lat);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if (lat != 0 || dut_res() !== e) begin
            n_fail++;
            $display("FAIL bp_first: lat=%0d C=%h, want 0 and %h", lat, c_out, e.c);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a_in = 8'($urandom); b_in = 8'($urandom); sel = 4'h6;
            @(posedge clk); #1;
            n_checks++;
            if (dut_res() !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: C=%h out_valid=%b in_ready=%b, want %h/1/0", i, c_out, out_valid, in_ready, e.c);
            end
        end
        a_in = 8'h12; b_in = 8'h34; sel = 4'h2;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_res() !== e) begin
            n_fail++;
            $display("FAIL bp_transfer: out_valid=%b in_ready=%b C=%h, want 0/1/%h", out_valid, in_ready, c_out, e.c);
        end
        exp_q.push_back(model(8'h12, 8'h34, 4'h2));
        @(posedge clk); #1;
        in_valid = 1'b0;
        e2 = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || dut_res() !== e2) begin
            n_fail++;
            $display("FAIL bp_next_op: out_valid=%b C=%h, want 1/%h", out_valid, c_out, e2.c);
        end
        transfer();
    endtask

    task automatic test_back_to_back();
        res_t       e;
        logic [3:0] s;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s = 4'(i % 8);
            a_in = 8'($urandom); b_in = 8'($urandom); sel = s;
            exp_q.push_back(model(a_in, b_in, s));
            @(posedge clk); #1;
            a_in = 8'($urandom); b_in = 8'($urandom); sel = 4'h1;
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || dut_res() !== e) begin
                n_fail++;
                $display("FAIL b2b%0d_deliver: out_valid=%b in_ready=%b C=%h, want 1/0/%h", i, out_valid, in_ready, c_out, e.c);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b%0d_rearm: out_valid=%b in_ready=%b, want 0/1", i, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int         w;
        int         lat;
        res_t       e;
        logic [3:0] s;
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 24; i++) begin
            s = (i % 6 == 5) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            a = 8'($urandom); b = 8'($urandom);
            issue(a, b, s, w);
            wait_out(lat);
            n_checks++;
            if (w != 0 || lat != exp_lat(s)) begin
                n_fail++;
                $display("FAIL rnd%0d_latency: accept_wait=%0d lat=%0d, want 0 and %0d", i, w, lat, exp_lat(s));
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                n_checks++;
                if (dut_res() !== e) begin
                    n_fail++;
                    $display("FAIL rnd%0d_result sel=%h A=%h B=%h: got %h/%b%b%b%b%b want %h/%b%b%b%b%b",
                             i, s, a, b, c_out, zero, negative, carry, overflow, err,
                             e.c, e.z, e.n, e.cy, e.ov, e.er);
                end
            end
            transfer();
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
